// File: rtl/mem_copy_dma_pkg.sv
// Shared types and constants for the word-copy DMA engine.
package mem_copy_dma_pkg;

  localparam int unsigned DMA_LEN_W   = 16;
  localparam logic [31:0] ZERO_WORD   = '0;
  localparam logic [31:0] WORD_STRIDE = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// Word-granular memory copy DMA initiator sharing the word RAM via request/grant.
// Optional pattern-fill mode is enabled by defining MEM_COPY_DMA_FILL_EN.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int unsigned LEN_W = DMA_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  input  logic [31:0]      mem_data_i
`ifdef MEM_COPY_DMA_FILL_EN
  ,
  input  logic             fill_i,
  input  logic [31:0]      pattern_i
`endif
);

  state_t           state_q, state_d;
  logic [31:0]      src_q, dst_q, buf_q, pattern_q;
  logic [31:0]      addr_q, data_q;
  logic [LEN_W-1:0] count_q;
  logic             err_q, fill_q;
  logic             fill_in, bad_align;
  logic [31:0]      pattern_in;

`ifdef MEM_COPY_DMA_FILL_EN
  assign fill_in    = fill_i;
  assign pattern_in = pattern_i;
`else
  assign fill_in    = 1'b0;
  assign pattern_in = ZERO_WORD;
`endif

  // Fill mode never reads the source, so only the destination must be aligned.
  assign bad_align = fill_in ? !is_word_aligned(dst_i)
                             : !(is_word_aligned(src_i) && is_word_aligned(dst_i));

  assign busy_o = (state_q != ST_IDLE);
  assign err_o  = err_q;

  always_comb begin
    state_d    = state_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = addr_q;
    mem_data_o = data_q;
    done_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (bad_align || (len_i == '0)) state_d = ST_DONE;
          else                            state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = fill_q ? ST_WR : ST_RD;
      end
      ST_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = src_q;
        if (mem_gnt_i) state_d = ST_WR;
      end
      ST_WR: begin
        mem_req_o  = 1'b1;
        mem_addr_o = dst_q;
        mem_data_o = fill_q ? pattern_q : buf_q;
        mem_we_o   = mem_gnt_i;
        if (mem_gnt_i) begin
          if (count_q == LEN_W'(1)) state_d = ST_DONE;
          else                      state_d = fill_q ? ST_WR : ST_RD;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus address/data are re-registered every cycle so idle states replay the last driven value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q     <= ZERO_WORD;
      dst_q     <= ZERO_WORD;
      buf_q     <= ZERO_WORD;
      pattern_q <= ZERO_WORD;
      addr_q    <= ZERO_WORD;
      data_q    <= ZERO_WORD;
      count_q   <= '0;
      err_q     <= 1'b0;
      fill_q    <= 1'b0;
    end else begin
      addr_q <= mem_addr_o;
      data_q <= mem_data_o;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            src_q     <= src_i;
            dst_q     <= dst_i;
            count_q   <= len_i;
            err_q     <= bad_align;
            fill_q    <= fill_in;
            pattern_q <= pattern_in;
          end
        end
        ST_RD: begin
          if (mem_gnt_i) buf_q <= mem_data_i;
        end
        ST_WR: begin
          if (mem_gnt_i) begin
            if (!fill_q) src_q <= src_q + WORD_STRIDE;
            dst_q   <= dst_q + WORD_STRIDE;
            count_q <= count_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
